// File: rtl/fir_interp_serial.sv
// Polyphase interpolating FIR with a single time-shared multiplier: each accepted sample
// yields INTERP outputs, phase 0 first, one product per cycle per phase.
module fir_interp_serial #(
  parameter int INPUT_WIDTH       = 16,
  parameter int COEFF_WIDTH       = 8,
  parameter int OUTPUT_WIDTH      = 26,
  parameter int OUTPUT_WIDTH_FULL = 26,
  parameter int INTERP            = 4,
  parameter int NUM_TAPS          = 16,
  parameter int COEFFS [NUM_TAPS] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [INPUT_WIDTH-1:0]  din,
  output logic                    valid_out,
  output logic [OUTPUT_WIDTH-1:0] dout
);

  localparam int P      = NUM_TAPS / INTERP;
  localparam int PH_W   = $clog2(INTERP);
  localparam int K_W    = (P > 1) ? $clog2(P) : 1;
  localparam int IDX_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = INPUT_WIDTH + COEFF_WIDTH;
  localparam int FULL   = OUTPUT_WIDTH_FULL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic signed [INPUT_WIDTH-1:0]  x_q [P];
  logic signed [INPUT_WIDTH-1:0]  x_d [P];
  logic signed [FULL-1:0]         acc_q, acc_d;
  logic [K_W-1:0]                 k_q, k_d;
  logic [PH_W-1:0]                phase_q, phase_d;
  logic                           valid_out_q, valid_out_d;
  logic                           ready_in_q, ready_in_d;
  logic [OUTPUT_WIDTH-1:0]        dout_q, dout_d;

  logic signed [COEFF_WIDTH-1:0]  coeff_rom_s [NUM_TAPS];
  logic [IDX_W-1:0]               coeff_idx_s;
  logic signed [COEFF_WIDTH-1:0]  coeff_s;
  logic signed [PROD_W-1:0]       prod_s;
  logic signed [FULL-1:0]         acc_sum_s;
  logic [OUTPUT_WIDTH-1:0]        scaled_s;

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_rom
    assign coeff_rom_s[i] = COEFF_WIDTH'(COEFFS[i]);
  end

  // Tap k of phase p uses prototype coefficient h[p + k*INTERP].
  assign coeff_idx_s = IDX_W'(phase_q) + IDX_W'(k_q) * IDX_W'(INTERP);
  assign coeff_s     = coeff_rom_s[coeff_idx_s];
  assign prod_s      = x_q[k_q] * coeff_s;
  assign acc_sum_s   = acc_q + FULL'(prod_s);

  if (OUTPUT_WIDTH < FULL) begin : g_trunc
    assign scaled_s = acc_sum_s[FULL-1 -: OUTPUT_WIDTH];
  end else if (OUTPUT_WIDTH == FULL) begin : g_same
    assign scaled_s = acc_sum_s;
  end else begin : g_sext
    assign scaled_s = {{(OUTPUT_WIDTH - FULL){acc_sum_s[FULL-1]}}, acc_sum_s};
  end

  // Next-state and datapath: dout is loaded on the last MAC edge so it is valid during OUT.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    acc_d       = acc_q;
    k_d         = k_q;
    phase_d     = phase_q;
    dout_d      = dout_q;
    valid_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_in_q) begin
          for (int i = P - 1; i > 0; i--) begin
            x_d[i] = x_q[i-1];
          end
          x_d[0]  = $signed(din);
          phase_d = '0;
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_sum_s;
        if (k_q == K_W'(P - 1)) begin
          dout_d      = scaled_s;
          valid_out_d = 1'b1;
          state_d     = OUT;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      OUT: begin
        if (phase_q == PH_W'(INTERP - 1)) begin
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
          acc_d   = '0;
          k_d     = '0;
          state_d = MAC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_in_d = (state_d == IDLE);
  end

  // State and output registers; reset discards any partial output and clears the delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '{default: '0};
      acc_q       <= '0;
      k_q         <= '0;
      phase_q     <= '0;
      valid_out_q <= 1'b0;
      ready_in_q  <= 1'b1;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      phase_q     <= phase_d;
      valid_out_q <= valid_out_d;
      ready_in_q  <= ready_in_d;
      dout_q      <= dout_d;
    end
  end

  assign ready_in  = ready_in_q;
  assign valid_out = valid_out_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_fir_interp_serial.sv
// Directed and random stimulus for fir_interp_serial: a full-width instance with the
// default prototype and a 16-bit truncating instance with all coefficients -128.
module tb_fir_interp_serial;

  localparam int L = 4;
  localparam int P = 4;
  localparam int H_A [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] din;
  logic        ready_a, valid_a, ready_t, valid_t;
  logic [25:0] dout_a;
  logic [15:0] dout_t;

  int     errors = 0;
  int     checks = 0;
  int     hist [P];
  longint exp_a [L];
  longint exp_t [L];
  longint last_a, last_t;

  always #5 clk = ~clk;

  fir_interp_serial dut_a (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_a),
    .din(din), .valid_out(valid_a), .dout(dout_a)
  );

  fir_interp_serial #(
    .OUTPUT_WIDTH(16), .OUTPUT_WIDTH_FULL(26),
    .COEFFS('{-128, -128, -128, -128, -128, -128, -128, -128,
              -128, -128, -128, -128, -128, -128, -128, -128})
  ) dut_t (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_t),
    .din(din), .valid_out(valid_t), .dout(dout_t)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference: each phase output is the dot product of the delay line with its sub-filter,
  // wrapped to 26 bits; the narrow instance keeps the top 16 bits (floor divide by 1024).
  task automatic model_accept(input int d);
    for (int k = P - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    for (int p = 0; p < L; p++) begin
      longint sa;
      longint st;
      logic signed [25:0] wa;
      logic signed [25:0] wt;
      sa = 0;
      st = 0;
      for (int k = 0; k < P; k++) begin
        sa += longint'(hist[k]) * longint'(H_A[p + k * L]);
        st += longint'(hist[k]) * -128;
      end
      wa = sa[25:0];
      wt = st[25:0];
      exp_a[p] = longint'(wa);
      exp_t[p] = longint'(wt) >>> 10;
    end
  endtask

  // Called at a negedge where the block is idle; ends at the negedge where it is idle again.
  task automatic send(input logic [15:0] d, input bit hold, input longint dc);
    chk("ready_pre", ready_a, 1);
    valid_in = 1'b1;
    din      = d;
    @(posedge clk);
    model_accept(int'($signed(d)));
    for (int j = 0; j < 21; j++) begin
      @(negedge clk);
      if (hold) din = 16'($urandom);
      else      valid_in = 1'b0;
      if (j < 20) begin
        chk("valid_out", valid_a, ((j + 1) % 5 == 0));
        chk("valid_out_t", valid_t, ((j + 1) % 5 == 0));
        chk("ready_busy", ready_a, 0);
        if ((j + 1) % 5 == 0) begin
          last_a = exp_a[(j + 1) / 5 - 1];
          last_t = exp_t[(j + 1) / 5 - 1];
          chk("dout", $signed(dout_a), last_a);
          chk("dout_trunc", $signed(dout_t), last_t);
          if (dc != 0) chk("dout_dc", $signed(dout_a), dc);
        end else begin
          chk("dout_hold", $signed(dout_a), last_a);
        end
      end else begin
        chk("ready_back", ready_a, 1);
        chk("ready_back_t", ready_t, 1);
        chk("valid_idle", valid_a, 0);
      end
    end
  endtask

  task automatic impulse();
    send(16'd1, 1'b0, 0);
    for (int i = 0; i < 3; i++) send(16'd0, 1'b0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    din      = '0;
    for (int k = 0; k < P; k++) hist[k] = 0;
    last_a = 0;
    last_t = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready_a, 1);
    chk("rst_valid", valid_a, 0);
    chk("rst_dout", $signed(dout_a), 0);
    chk("rst_dout_t", $signed(dout_t), 0);

    impulse();

    for (int i = 0; i < 6; i++) send(16'd100, 1'b1, (i >= 3) ? 1800 : 0);
    valid_in = 1'b0;

    for (int i = 0; i < 8; i++) send(16'($urandom), 1'b1, 0);
    valid_in = 1'b0;

    for (int i = 0; i < 4; i++) send(16'h7fff, 1'b0, 0);
    for (int i = 0; i < 4; i++) send(16'h8000, 1'b0, 0);
    chk("trunc_extreme", $signed(dout_t), 16384);

    // Reset two cycles after an accept: the output in flight must never appear.
    valid_in = 1'b1;
    din      = 16'h7fff;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < P; k++) hist[k] = 0;
    last_a = 0;
    last_t = 0;
    chk("rst_mid_ready", ready_a, 1);
    chk("rst_mid_dout", $signed(dout_a), 0);
    for (int j = 0; j < 25; j++) begin
      chk("rst_mid_no_valid", valid_a, 0);
      @(negedge clk);
    end
    impulse();

    for (int i = 0; i < 6; i++) send(16'($urandom), 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
